// File: rtl/pattern_event_logger.sv
// Logs Y/Z detection pulses as {type, ts} records in a DEPTH-entry FIFO and keeps saturating counts of Y, Z and dropped records.
// Latency: a record pushed at a sampling edge is visible on ev_valid/ev_data from the next cycle; pop on ev_valid & ev_ready.
// Backpressure: ev_ready low holds the head stable; arrivals while full with no pop are dropped (counted, sticky overflow).
// Optional: PATTERN_EVENT_LOGGER_TIMESTAMP_EN enables the free-running timestamp; otherwise the ts field reads 0.
module pattern_event_logger #(
    parameter int DEPTH = 4,
    parameter int TS_W  = 8,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              y_in,
    input  logic              z_in,
    input  logic              cnt_clr,
    input  logic              ev_ready,
    output logic              ev_valid,
    output logic [TS_W+1:0]   ev_data,
    output logic [CNT_W-1:0]  y_count,
    output logic [CNT_W-1:0]  z_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic              overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    logic [TS_W+1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic [TS_W-1:0]  ts_now;
    logic [1:0]       ev_type;
    logic             rec_vld;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

`ifdef PATTERN_EVENT_LOGGER_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    assign ts_now = ts_q;
`else
    assign ts_now = '0;
`endif

    assign ev_type  = {z_in, y_in};
    assign rec_vld  = |ev_type;
    assign full     = (occ == OCC_FULL);
    assign ev_valid = (occ != '0);
    assign pop      = ev_valid & ev_ready;
    // A full FIFO still takes the arrival when the head leaves on the same edge.
    assign push     = rec_vld & (~full | pop);
    assign drop     = rec_vld & full & ~pop;
    assign ev_data  = ev_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {ev_type, ts_now};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Counters saturate at all-ones; cnt_clr wins over same-cycle increments.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_count    <= '0;
            z_count    <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (cnt_clr) begin
            y_count    <= '0;
            z_count    <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (y_in && !(&y_count)) begin
                y_count <= y_count + 1'b1;
            end
            if (z_in && !(&z_count)) begin
                z_count <= z_count + 1'b1;
            end
            if (drop && !(&drop_count)) begin
                drop_count <= drop_count + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pattern_event_logger.sv
// Directed bench for pattern_event_logger: reset, single/dual events, overflow, full push+pop, saturation/wrap, async reset.
module tb_pattern_event_logger;

    logic       clk;
    logic       reset;
    logic       y_in;
    logic       z_in;
    logic       cnt_clr;
    logic       ev_ready;
    logic       ev_valid;
    logic [9:0] ev_data;
    logic [7:0] y_count;
    logic [7:0] z_count;
    logic [7:0] drop_count;
    logic       overflow;

    int errors;
    int checks;
    int cyc;

`ifdef PATTERN_EVENT_LOGGER_TIMESTAMP_EN
    localparam logic [7:0] TS_MASK = 8'hFF;
`else
    localparam logic [7:0] TS_MASK = 8'h00;
`endif

    pattern_event_logger #(.DEPTH(4), .TS_W(8), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .y_in       (y_in),
        .z_in       (z_in),
        .cnt_clr    (cnt_clr),
        .ev_ready   (ev_ready),
        .ev_valid   (ev_valid),
        .ev_data    (ev_data),
        .y_count    (y_count),
        .z_count    (z_count),
        .drop_count (drop_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected record: timestamp equals the number of edges since reset release, mod 256.
    function automatic logic [9:0] rec(input logic [1:0] t, input int c);
        logic [7:0] ts;
        ts = 8'(c) & TS_MASK;
        return {t, ts};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        y_in = 1'b0; z_in = 1'b0; cnt_clr = 1'b0; ev_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic idle_until(input int n);
        while (cyc < n) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        y_in = 1'b0; z_in = 1'b0; cnt_clr = 1'b0; ev_ready = 1'b0;
        tick();
        checks++;
        if ({ev_valid, ev_data, y_count, z_count, drop_count, overflow} !== 35'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%b d=%h y=%0d z=%0d dr=%0d ov=%b required all 0",
                     ev_valid, ev_data, y_count, z_count, drop_count, overflow);
        end
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic test_single_y();
        do_reset();
        ev_ready = 1'b1;
        idle_until(5);
        y_in = 1'b1;
        tick();
        y_in = 1'b0;
        checks++;
        if (ev_valid !== 1'b1 || ev_data !== rec(2'b01, 5)) begin
            errors++;
            $display("FAIL single_y_record: got v=%b d=%h required v=1 d=%h", ev_valid, ev_data, rec(2'b01, 5));
        end
        checks++;
        if (y_count !== 8'd1 || z_count !== 8'd0) begin
            errors++;
            $display("FAIL single_y_count: got y=%0d z=%0d required y=1 z=0", y_count, z_count);
        end
        tick();
        checks++;
        if (ev_valid !== 1'b0 || ev_data !== 10'd0) begin
            errors++;
            $display("FAIL single_y_empty: got v=%b d=%h required v=0 d=000", ev_valid, ev_data);
        end
    endtask

    task automatic test_both();
        do_reset();
        ev_ready = 1'b1;
        idle_until(9);
        y_in = 1'b1; z_in = 1'b1;
        tick();
        y_in = 1'b0; z_in = 1'b0;
        checks++;
        if (ev_valid !== 1'b1 || ev_data !== rec(2'b11, 9)) begin
            errors++;
            $display("FAIL both_record: got v=%b d=%h required v=1 d=%h", ev_valid, ev_data, rec(2'b11, 9));
        end
        checks++;
        if (y_count !== 8'd1 || z_count !== 8'd1) begin
            errors++;
            $display("FAIL both_count: got y=%0d z=%0d required y=1 z=1", y_count, z_count);
        end
        tick();
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL both_single_record: got v=%b required v=0", ev_valid);
        end
        z_in = 1'b1;
        tick();
        z_in = 1'b0;
        checks++;
        if (ev_data !== rec(2'b10, 11)) begin
            errors++;
            $display("FAIL z_only_record: got d=%h required d=%h", ev_data, rec(2'b10, 11));
        end
    endtask

    task automatic test_overflow();
        do_reset();
        ev_ready = 1'b0;
        y_in = 1'b1;
        repeat (6) tick();
        y_in = 1'b0;
        checks++;
        if (drop_count !== 8'd2 || overflow !== 1'b1 || y_count !== 8'd6) begin
            errors++;
            $display("FAIL overflow_counts: got dr=%0d ov=%b y=%0d required dr=2 ov=1 y=6",
                     drop_count, overflow, y_count);
        end
        tick();
        checks++;
        if (ev_valid !== 1'b1 || ev_data !== rec(2'b01, 0)) begin
            errors++;
            $display("FAIL overflow_head_stable: got v=%b d=%h required v=1 d=%h", ev_valid, ev_data, rec(2'b01, 0));
        end
        ev_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ev_valid !== 1'b1 || ev_data !== rec(2'b01, i)) begin
                errors++;
                $display("FAIL overflow_drain_%0d: got v=%b d=%h required v=1 d=%h", i, ev_valid, ev_data, rec(2'b01, i));
            end
            tick();
        end
        checks++;
        if (ev_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_drained: got v=%b ov=%b required v=0 ov=1", ev_valid, overflow);
        end
        ev_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        do_reset();
        ev_ready = 1'b0;
        y_in = 1'b1;
        repeat (4) tick();
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        checks++;
        if (drop_count !== 8'd0 || overflow !== 1'b0 || ev_data !== rec(2'b01, 1)) begin
            errors++;
            $display("FAIL full_push_pop: got dr=%0d ov=%b d=%h required dr=0 ov=0 d=%h",
                     drop_count, overflow, ev_data, rec(2'b01, 1));
        end
        // Still full: one more arrival without pop must drop.
        tick();
        y_in = 1'b0;
        checks++;
        if (drop_count !== 8'd1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL full_still_full: got dr=%0d ov=%b required dr=1 ov=1", drop_count, overflow);
        end
        ev_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (ev_data !== rec(2'b01, i)) begin
                errors++;
                $display("FAIL full_drain_%0d: got d=%h required d=%h", i, ev_data, rec(2'b01, i));
            end
            tick();
        end
        checks++;
        if (ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_drained: got v=%b required v=0", ev_valid);
        end
        ev_ready = 1'b0;
    endtask

    task automatic test_saturate_wrap();
        do_reset();
        ev_ready = 1'b1;
        y_in = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 254 || i == 255 || i == 256) begin
                checks++;
                if (ev_valid !== 1'b1 || ev_data !== rec(2'b01, i)) begin
                    errors++;
                    $display("FAIL ts_wrap_%0d: got v=%b d=%h required v=1 d=%h", i, ev_valid, ev_data, rec(2'b01, i));
                end
            end
        end
        checks++;
        if (y_count !== 8'd255 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL y_saturate: got y=%0d dr=%0d required y=255 dr=0", y_count, drop_count);
        end
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        y_in = 1'b0;
        checks++;
        if (y_count !== 8'd0 || ev_valid !== 1'b1 || ev_data !== rec(2'b01, 300)) begin
            errors++;
            $display("FAIL cnt_clr: got y=%0d v=%b d=%h required y=0 v=1 d=%h", y_count, ev_valid, ev_data, rec(2'b01, 300));
        end
        tick();
        ev_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        ev_ready = 1'b0;
        y_in = 1'b1; z_in = 1'b1;
        repeat (3) tick();
        y_in = 1'b0; z_in = 1'b0;
        checks++;
        if (ev_valid !== 1'b1 || y_count !== 8'd3 || z_count !== 8'd3) begin
            errors++;
            $display("FAIL async_pre: got v=%b y=%0d z=%0d required v=1 y=3 z=3", ev_valid, y_count, z_count);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({ev_valid, ev_data, y_count, z_count, drop_count, overflow} !== 35'd0) begin
            errors++;
            $display("FAIL async_reset: got v=%b d=%h y=%0d z=%0d dr=%0d ov=%b required all 0",
                     ev_valid, ev_data, y_count, z_count, drop_count, overflow);
        end
        tick();
        reset = 1'b0;
        cyc = 0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc = 0;
        reset = 1'b1;
        y_in = 1'b0; z_in = 1'b0; cnt_clr = 1'b0; ev_ready = 1'b0;
        test_reset();
        test_single_y();
        test_both();
        test_overflow();
        test_full_push_pop();
        test_saturate_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
